// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage: state encoding,
// default geometry and stall-counter sizing.
// Optional feature macro: PIPE_SKID_EN (adds a one-entry skid slot).
package pipe_pkg;

  // Default stage geometry
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned NUM_DATA_DEF = 7;
  localparam int unsigned CTRL_W_DEF   = 8;
  localparam int unsigned NUM_CTRL_DEF = 2;

  // Stall counter width and its saturation value
  localparam int unsigned STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_SAT = {STALL_CNT_W{1'b1}};

  // Stage occupancy; ST_FULL_SKID is only reachable when the skid slot exists
  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_FULL_SKID = 2'd2
  } pipe_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// One holding register of the stage: valid flag, data words and control fields.
// A clear drops the valid flag and zeroes control only; data keeps its last value.
module pipe_slot #(
  parameter int unsigned DW = 112,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] d_data,
  input  logic [CW-1:0] d_ctrl,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [CW-1:0] ctrl
);

  // Slot register: clear wins over load so a bubble always carries zero control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      ctrl  <= d_ctrl;
    end
  end

endmodule : pipe_slot

// File: rtl/pipe_stage_hs.sv
// Handshaked CPU pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries NUM_DATA data words and NUM_CTRL control fields with valid/ready,
// flush-to-bubble with zeroed control, and a saturating stall counter.
// Optional feature macro: PIPE_SKID_EN -- one-entry skid slot, registered in_ready.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_DATA = NUM_DATA_DEF,
  parameter int unsigned CTRL_W   = CTRL_W_DEF,
  parameter int unsigned NUM_CTRL = NUM_CTRL_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_DATA*DATA_W-1:0]   in_data,
  input  logic [NUM_CTRL*CTRL_W-1:0]   in_ctrl,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_DATA*DATA_W-1:0]   out_data,
  output logic [NUM_CTRL*CTRL_W-1:0]   out_ctrl,
  output logic [STALL_CNT_W-1:0]       stall_cnt
);

  localparam int unsigned DW = NUM_DATA * DATA_W;
  localparam int unsigned CW = NUM_CTRL * CTRL_W;

  pipe_state_e state_q, state_d;

  logic          accept_c;
  logic          consume_c;
  logic          main_load;
  logic          main_clear;
  logic [DW-1:0] main_d_data;
  logic [CW-1:0] main_d_ctrl;

`ifdef PIPE_SKID_EN
  logic          main_from_skid;
  logic          skid_load;
  logic          skid_clear;
  logic          skid_valid;
  logic [DW-1:0] skid_data;
  logic [CW-1:0] skid_ctrl;
`endif

  assign accept_c  = in_valid & in_ready & ~flush;
  assign consume_c = out_valid & out_ready;

`ifdef PIPE_SKID_EN
  // Skid slot occupancy is exactly FULL_SKID, so in_ready comes straight from a flop
  assign in_ready = ~skid_valid;
`else
  // Ready whenever the stage is empty or its beat leaves this cycle
  assign in_ready = ~out_valid | out_ready;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and slot control; flush overrides any move or load
  always_comb begin
    state_d    = state_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
`ifdef PIPE_SKID_EN
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
`endif
    if (flush) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
`ifdef PIPE_SKID_EN
      skid_clear = 1'b1;
`endif
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (consume_c && accept_c) begin
            main_load = 1'b1;
          end else if (consume_c) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
`ifdef PIPE_SKID_EN
          end else if (accept_c) begin
            state_d   = ST_FULL_SKID;
            skid_load = 1'b1;
`endif
          end
        end
`ifdef PIPE_SKID_EN
        ST_FULL_SKID: begin
          if (consume_c) begin
            state_d        = ST_FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
`endif
        default: begin
          state_d    = ST_EMPTY;
          main_clear = 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_EN
  // Main slot refills from the skid slot when draining a backed-up beat
  assign main_d_data = main_from_skid ? skid_data : in_data;
  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
`else
  assign main_d_data = in_data;
  assign main_d_ctrl = in_ctrl;
`endif

  // Main slot drives the stage outputs directly
  pipe_slot #(
    .DW (DW),
    .CW (CW)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .clear  (main_clear),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .valid  (out_valid),
    .data   (out_data),
    .ctrl   (out_ctrl)
  );

`ifdef PIPE_SKID_EN
  // Skid slot absorbs the beat accepted while downstream is stalled
  pipe_slot #(
    .DW (DW),
    .CW (CW)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_data (in_data),
    .d_ctrl (in_ctrl),
    .valid  (skid_valid),
    .data   (skid_data),
    .ctrl   (skid_ctrl)
  );
`endif

  // Saturating count of cycles where a valid beat is held back by downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != STALL_SAT)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule : pipe_stage_hs
